// File: rtl/rf_pkg.sv
// Shared register-file write types and constants used by the writeback stage
// and the RF write-port arbiter.
package rf_pkg;

    localparam int RF_IDX_W  = 5;
    localparam int RF_DATA_W = 16;

    // Control opcodes shared with the writeback stage
    localparam logic [3:0] LOAD  = 4'b1100;
    localparam logic [3:0] STORE = 4'b1110;

    typedef struct packed {
        logic [RF_IDX_W-1:0]  index;
        logic [RF_DATA_W-1:0] data;
    } rf_write_t;

    typedef enum logic {
        ARB_RUN   = 1'b0,
        ARB_STALL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO holding queued long-latency-unit RF writes; exposes
// per-entry valid/index so the arbiter can answer register hazard queries.
module rf_arb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int IDX_W  = RF_IDX_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [IDX_W-1:0]       push_index,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [IDX_W-1:0]       head_index,
    output logic [DATA_W-1:0]      head_data,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH*IDX_W-1:0] entry_index
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]  index_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // NOTE: storage is not reset; entry_valid alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            index_mem[wr_ptr] <= push_index;
            data_mem[wr_ptr]  <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_index = index_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_index[i*IDX_W +: IDX_W] = index_mem[i];
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between writeback (always wins) and a queued
// long-latency unit. Define RF_ARB_BYPASS_EN to let an LU result skip an empty FIFO.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int IDX_W        = RF_IDX_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  wb_index,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_en,
    input  logic              lu_valid,
    input  logic [IDX_W-1:0]  lu_index,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              wb_stall,
    input  logic [IDX_W-1:0]  pend_q_index,
    output logic              pend_hit,
    output logic              stall_violation,
    output logic [IDX_W-1:0]  write_index_rf,
    output logic [DATA_W-1:0] write_data_rf,
    output logic              write_en_rf
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [IDX_W-1:0]        head_index;
    logic [DATA_W-1:0]       head_data;
    logic [QDEPTH-1:0]       entry_valid;
    logic [QDEPTH*IDX_W-1:0] entry_index;
    logic                    push;
    logic                    pop;
    logic                    lu_direct;
    logic                    head_lost;
    logic [AGE_W-1:0]        age;
    arb_state_t              state;

`ifdef RF_ARB_BYPASS_EN
    assign lu_direct = lu_valid && !wb_en && fifo_empty;
`else
    assign lu_direct = 1'b0;
`endif

    assign lu_ready  = !fifo_full;
    assign push      = lu_valid && lu_ready && !lu_direct;
    assign pop       = !wb_en && !fifo_empty;
    assign head_lost = !fifo_empty && !pop;

    rf_arb_fifo #(
        .DEPTH  (QDEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_index  (lu_index),
        .push_data   (lu_data),
        .pop         (pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_index  (head_index),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_index (entry_index)
    );

    // NOTE: assign the default before the loop so no path leaves pend_hit
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (entry_valid[i] && (entry_index[i*IDX_W +: IDX_W] == pend_q_index)) begin
                pend_hit = 1'b1;
            end
        end
    end

    // Starvation FSM: the age counter keeps running in STALL, only a pop ends it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ARB_RUN;
            age             <= '0;
            stall_violation <= 1'b0;
        end else begin
            if (wb_en && (state == ARB_STALL)) begin
                stall_violation <= 1'b1;
            end
            if (fifo_empty || pop) begin
                age <= '0;
            end else if (age != AGE_W'(STARVE_LIMIT)) begin
                age <= age + AGE_W'(1);
            end
            case (state)
                ARB_RUN: begin
                    if (head_lost && (age == AGE_W'(STARVE_LIMIT - 1))) begin
                        state <= ARB_STALL;
                    end
                end
                ARB_STALL: begin
                    if (pop) begin
                        state <= ARB_RUN;
                    end
                end
                default: state <= ARB_RUN;
            endcase
        end
    end

    assign wb_stall = (state == ARB_STALL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_rf    <= 1'b0;
            write_index_rf <= '0;
            write_data_rf  <= '0;
        end else begin
            write_en_rf <= wb_en || pop || lu_direct;
            if (wb_en) begin
                write_index_rf <= wb_index;
                write_data_rf  <= wb_data;
            end else if (pop) begin
                write_index_rf <= head_index;
                write_data_rf  <= head_data;
            end else if (lu_direct) begin
                write_index_rf <= lu_index;
                write_data_rf  <= lu_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, WB path, LU path, full FIFO,
// starvation stall and hazard/violation reporting.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  wb_index;
    logic [15:0] wb_data;
    logic        wb_en;
    logic        lu_valid;
    logic [4:0]  lu_index;
    logic [15:0] lu_data;
    logic        lu_ready;
    logic        wb_stall;
    logic [4:0]  pend_q_index;
    logic        pend_hit;
    logic        stall_violation;
    logic [4:0]  write_index_rf;
    logic [15:0] write_data_rf;
    logic        write_en_rf;

    int n_compared   = 0;
    int n_mismatched = 0;

    rf_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_index        (wb_index),
        .wb_data         (wb_data),
        .wb_en           (wb_en),
        .lu_valid        (lu_valid),
        .lu_index        (lu_index),
        .lu_data         (lu_data),
        .lu_ready        (lu_ready),
        .wb_stall        (wb_stall),
        .pend_q_index    (pend_q_index),
        .pend_hit        (pend_hit),
        .stall_violation (stall_violation),
        .write_index_rf  (write_index_rf),
        .write_data_rf   (write_data_rf),
        .write_en_rf     (write_en_rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wb_en = 1'b1; wb_index = 5'd1; wb_data = 16'd1;
        lu_valid = 1'b1; lu_index = 5'd2; lu_data = 16'd2;
        pend_q_index = 5'd2;
        tick(); tick();
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL reset_en: got %0b want 0", write_en_rf);
        end
        n_compared++;
        if (lu_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL reset_lu_ready: got %0b want 1", lu_ready);
        end
        n_compared++;
        if ({wb_stall, stall_violation, write_index_rf, write_data_rf} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: stall=%0b viol=%0b idx=%0d data=%0d want all 0",
                     wb_stall, stall_violation, write_index_rf, write_data_rf);
        end
        n_compared++;
        if (pend_hit !== 1'b0) begin
            n_mismatched++; $display("FAIL reset_no_push: pend_hit got %0b want 0", pend_hit);
        end
        rst_n = 1'b1; wb_en = 1'b0; lu_valid = 1'b0;
        tick();
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL release_idle_en: got %0b want 0", write_en_rf);
        end
    endtask

    task automatic test_wb_only();
        wb_en = 1'b1; wb_index = 5'd3; wb_data = 16'd10;
        tick();
        wb_en = 1'b0;
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd3, 16'd10}) begin
            n_mismatched++;
            $display("FAIL wb_write: got en=%0b idx=%0d data=%0d want en=1 idx=3 data=10",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        tick();
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL wb_idle_after: got %0b want 0", write_en_rf);
        end
    endtask

    task automatic test_lu_idle();
        lu_valid = 1'b1; lu_index = 5'd7; lu_data = 16'd11;
        #1;
        n_compared++;
        if (lu_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL lu_ready_empty: got %0b want 1", lu_ready);
        end
        tick();
        lu_valid = 1'b0;
`ifndef RF_ARB_BYPASS_EN
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL lu_enqueue_cycle_en: got %0b want 0", write_en_rf);
        end
        tick();
`endif
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd7, 16'd11}) begin
            n_mismatched++;
            $display("FAIL lu_write: got en=%0b idx=%0d data=%0d want en=1 idx=7 data=11",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        tick();
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL lu_single_write: got %0b want 0", write_en_rf);
        end
    endtask

    task automatic test_conflict_full();
        wb_en = 1'b1; wb_index = 5'd1; wb_data = 16'd100;
        lu_valid = 1'b1; lu_index = 5'd8; lu_data = 16'd200;
        tick();
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd1, 16'd100}) begin
            n_mismatched++;
            $display("FAIL conflict_wb_wins: got en=%0b idx=%0d data=%0d want en=1 idx=1 data=100",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        n_compared++;
        if (lu_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL lu_ready_one: got %0b want 1", lu_ready);
        end
        lu_index = 5'd9; lu_data = 16'd201; wb_data = 16'd101;
        tick();
        // FIFO now full; this LU request must not be accepted
        wb_en = 1'b0; lu_index = 5'd10; lu_data = 16'd202;
        #1;
        n_compared++;
        if (lu_ready !== 1'b0) begin
            n_mismatched++; $display("FAIL lu_ready_full: got %0b want 0", lu_ready);
        end
        tick();
        lu_valid = 1'b0;
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd8, 16'd200}) begin
            n_mismatched++;
            $display("FAIL drain_first: got en=%0b idx=%0d data=%0d want en=1 idx=8 data=200",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        n_compared++;
        if (lu_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL lu_ready_after_pop: got %0b want 1", lu_ready);
        end
        tick();
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd9, 16'd201}) begin
            n_mismatched++;
            $display("FAIL drain_second: got en=%0b idx=%0d data=%0d want en=1 idx=9 data=201",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        tick();
        n_compared++;
        if (write_en_rf !== 1'b0) begin
            n_mismatched++; $display("FAIL drain_empty: got %0b want 0", write_en_rf);
        end
    endtask

    task automatic test_starvation();
        wb_en = 1'b1; wb_index = 5'd2; wb_data = 16'd50;
        lu_valid = 1'b1; lu_index = 5'd12; lu_data = 16'd300;
        tick();
        lu_valid = 1'b0;
        tick(); tick(); tick();
        n_compared++;
        if (wb_stall !== 1'b0) begin
            n_mismatched++; $display("FAIL stall_early: got %0b want 0", wb_stall);
        end
        tick();
        n_compared++;
        if (wb_stall !== 1'b1) begin
            n_mismatched++; $display("FAIL stall_raised: got %0b want 1", wb_stall);
        end
        wb_en = 1'b0;
        tick();
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd12, 16'd300}) begin
            n_mismatched++;
            $display("FAIL starved_head_write: got en=%0b idx=%0d data=%0d want en=1 idx=12 data=300",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        n_compared++;
        if ({wb_stall, stall_violation} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL stall_release: stall=%0b viol=%0b want 0 0", wb_stall, stall_violation);
        end
        tick();
    endtask

    task automatic test_hazard_violation();
        wb_en = 1'b1; wb_index = 5'd4; wb_data = 16'd60;
        lu_valid = 1'b1; lu_index = 5'd5; lu_data = 16'd400;
        pend_q_index = 5'd5;
        #1;
        n_compared++;
        if (pend_hit !== 1'b0) begin
            n_mismatched++; $display("FAIL pend_excludes_push: got %0b want 0", pend_hit);
        end
        tick();
        lu_valid = 1'b0;
        #1;
        n_compared++;
        if (pend_hit !== 1'b1) begin
            n_mismatched++; $display("FAIL pend_hit_5: got %0b want 1", pend_hit);
        end
        pend_q_index = 5'd6;
        #1;
        n_compared++;
        if (pend_hit !== 1'b0) begin
            n_mismatched++; $display("FAIL pend_miss_6: got %0b want 0", pend_hit);
        end
        pend_q_index = 5'd5;
        tick(); tick(); tick(); tick();
        n_compared++;
        if (wb_stall !== 1'b1) begin
            n_mismatched++; $display("FAIL hazard_stall: got %0b want 1", wb_stall);
        end
        wb_index = 5'd20; wb_data = 16'd77;
        tick();
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf} !== {1'b1, 5'd20, 16'd77}) begin
            n_mismatched++;
            $display("FAIL violation_wb_write: got en=%0b idx=%0d data=%0d want en=1 idx=20 data=77",
                     write_en_rf, write_index_rf, write_data_rf);
        end
        n_compared++;
        if ({stall_violation, wb_stall} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL violation_set: viol=%0b stall=%0b want 1 1", stall_violation, wb_stall);
        end
        wb_en = 1'b0;
        #1;
        n_compared++;
        if (pend_hit !== 1'b1) begin
            n_mismatched++; $display("FAIL pend_includes_pop: got %0b want 1", pend_hit);
        end
        tick();
        n_compared++;
        if ({write_en_rf, write_index_rf, write_data_rf, wb_stall} !== {1'b1, 5'd5, 16'd400, 1'b0}) begin
            n_mismatched++;
            $display("FAIL hazard_head_write: got en=%0b idx=%0d data=%0d stall=%0b want 1 5 400 0",
                     write_en_rf, write_index_rf, write_data_rf, wb_stall);
        end
        n_compared++;
        if (pend_hit !== 1'b0) begin
            n_mismatched++; $display("FAIL pend_cleared: got %0b want 0", pend_hit);
        end
        tick();
        n_compared++;
        if (stall_violation !== 1'b1) begin
            n_mismatched++; $display("FAIL violation_sticky: got %0b want 1", stall_violation);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; wb_index = '0; wb_data = '0;
        lu_valid = 1'b0; lu_index = '0; lu_data = '0; pend_q_index = '0;
        test_reset();
        test_wb_only();
        test_lu_idle();
        test_conflict_full();
        test_starvation();
        test_hazard_violation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
